// File: rtl/ec_point_add_seq.sv
// Sequential affine point adder for short-Weierstrass curves over GF(P).
// One shared MSB-first interleaved modular multiplier and a binary
// extended-Euclid inverter; one operation in flight at a time.
module ec_point_add_seq #(
    parameter int               WIDTH = 256,
    parameter logic [WIDTH-1:0] P     = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F,
    parameter logic [WIDTH-1:0] A     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    input  logic             inf1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] y2,
    input  logic             inf2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] x3,
    output logic [WIDTH-1:0] y3,
    output logic             inf3
);

    // Step counter covers both the WIDTH+1 multiplier cycles and the inverter bound.
    localparam int               CW       = $clog2(2 * WIDTH + 4);
    localparam logic [CW-1:0]    C_ONE    = CW'(1);
    localparam logic [CW-1:0]    C_TWO    = CW'(2);
    localparam logic [CW-1:0]    MUL_LAST = CW'(WIDTH);
    localparam logic [CW-1:0]    INV_CAP  = CW'(2 * WIDTH + 1);
    localparam logic [WIDTH-1:0] F_ONE    = WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_CLASSIFY, S_NUM, S_DEN, S_INV, S_LAMBDA,
        S_SQ, S_X3, S_DIFF, S_MULY, S_Y3, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] x1_q, y1_q, x2_q, y2_q;
    logic             inf1_q, inf2_q, dbl_q;
    logic [WIDTH-1:0] num_q, den_q, lam_q, t_q, x3w_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] u_q, v_q, ix1_q, ix2_q;
    logic [WIDTH-1:0] x3_q, y3_q;
    logic             inf3_q;

    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[WIDTH]) d = d + {1'b0, P};
        return d[WIDTH-1:0];
    endfunction

    // x/2 mod P: add P first when x is odd so the shift is exact.
    function automatic logic [WIDTH-1:0] mod_half(input logic [WIDTH-1:0] a);
        logic [WIDTH:0] s;
        s = {1'b0, a} + (a[0] ? {1'b0, P} : '0);
        return s[WIDTH:1];
    endfunction

    // One multiplier iteration: acc = 2*acc + bit*a, kept below P.
    function automatic logic [WIDTH-1:0] mul_step(input logic [WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic             b);
        logic [WIDTH+1:0] t;
        t = {1'b0, acc, 1'b0};
        if (t >= {2'b00, P}) t = t - {2'b00, P};
        if (b) t = t + {2'b00, a};
        if (t >= {2'b00, P}) t = t - {2'b00, P};
        return t[WIDTH-1:0];
    endfunction

    logic             x_eq, y_eq, y1_zero, trivial;
    logic [WIDTH-1:0] mul_a, mul_b, mul_shift, mul_next;
    logic             mul_bit, mul_run;
    logic [WIDTH-1:0] den_init;
    logic [WIDTH-1:0] u_n, v_n, ix1_n, ix2_n;
    logic             inv_fin;

    assign x_eq      = (x1_q == x2_q);
    assign y_eq      = (y1_q == y2_q);
    assign y1_zero   = (y1_q == '0);
    assign trivial   = inf1_q | inf2_q | (x_eq & (~y_eq | y1_zero));
    assign mul_shift = mul_b << cnt_q;
    assign mul_bit   = mul_shift[WIDTH-1];
    assign mul_run   = (cnt_q < MUL_LAST);
    assign mul_next  = mul_step(acc_q, mul_a, mul_bit);
    assign den_init  = dbl_q ? mod_add(y1_q, y1_q) : mod_sub(x2_q, x1_q);
    assign inv_fin   = (u_q == F_ONE) | (v_q == F_ONE) | (u_q == '0) | (v_q == '0) |
                       (cnt_q >= INV_CAP);

    // Route multiplier operands according to which product the FSM is forming.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            S_NUM:    begin mul_a = x1_q;  mul_b = x1_q;  end
            S_LAMBDA: begin mul_a = num_q; mul_b = den_q; end
            S_SQ:     begin mul_a = lam_q; mul_b = lam_q; end
            S_MULY:   begin mul_a = lam_q; mul_b = t_q;   end
            default:  begin mul_a = '0;    mul_b = '0;    end
        endcase
    end

    // One inverter iteration; odd/odd pairs subtract and halve in the same cycle.
    always_comb begin
        u_n   = u_q;
        v_n   = v_q;
        ix1_n = ix1_q;
        ix2_n = ix2_q;
        if (!u_q[0]) begin
            u_n   = u_q >> 1;
            ix1_n = mod_half(ix1_q);
        end else if (!v_q[0]) begin
            v_n   = v_q >> 1;
            ix2_n = mod_half(ix2_q);
        end else if (u_q >= v_q) begin
            u_n   = (u_q - v_q) >> 1;
            ix1_n = mod_half(mod_sub(ix1_q, ix2_q));
        end else begin
            v_n   = (v_q - u_q) >> 1;
            ix2_n = mod_half(mod_sub(ix2_q, ix1_q));
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_CLASSIFY;
            S_CLASSIFY: state_d = trivial ? S_DONE : S_NUM;
            S_NUM:      if (!dbl_q || !mul_run) state_d = S_DEN;
            S_DEN:      if (!dbl_q || cnt_q == C_TWO) state_d = S_INV;
            S_INV:      if (inv_fin) state_d = S_LAMBDA;
            S_LAMBDA:   if (!mul_run) state_d = S_SQ;
            S_SQ:       if (!mul_run) state_d = S_X3;
            S_X3:       if (cnt_q == C_ONE) state_d = S_DIFF;
            S_DIFF:     state_d = S_MULY;
            S_MULY:     if (!mul_run) state_d = S_Y3;
            S_Y3:       state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    assign x3   = x3_q;
    assign y3   = y3_q;
    assign inf3 = inf3_q;

    // Datapath: operand capture, field arithmetic steps and result write-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            x1_q <= '0; y1_q <= '0; x2_q <= '0; y2_q <= '0;
            inf1_q <= 1'b0; inf2_q <= 1'b0; dbl_q <= 1'b0;
            num_q <= '0; den_q <= '0; lam_q <= '0; t_q <= '0; x3w_q <= '0;
            acc_q <= '0; cnt_q <= '0;
            u_q <= '0; v_q <= '0; ix1_q <= '0; ix2_q <= '0;
            x3_q <= '0; y3_q <= '0; inf3_q <= 1'b0;
        end else begin
            cnt_q <= (state_d != state_q) ? '0 : cnt_q + C_ONE;
            acc_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x1_q <= x1; y1_q <= y1; inf1_q <= inf1;
                        x2_q <= x2; y2_q <= y2; inf2_q <= inf2;
                    end
                end
                S_CLASSIFY: begin
                    dbl_q <= x_eq;
                    if (inf1_q) begin
                        x3_q <= x2_q; y3_q <= y2_q; inf3_q <= inf2_q;
                    end else if (inf2_q) begin
                        x3_q <= x1_q; y3_q <= y1_q; inf3_q <= 1'b0;
                    end else if (x_eq && (!y_eq || y1_zero)) begin
                        x3_q <= '0; y3_q <= '0; inf3_q <= 1'b1;
                    end
                end
                S_NUM: begin
                    if (!dbl_q)       num_q <= mod_sub(y2_q, y1_q);
                    else if (mul_run) acc_q <= mul_next;
                    else              num_q <= acc_q;
                end
                S_DEN: begin
                    if (dbl_q && cnt_q == '0)        t_q   <= mod_add(num_q, num_q);
                    else if (dbl_q && cnt_q == C_ONE) num_q <= mod_add(t_q, num_q);
                    else begin
                        if (dbl_q) num_q <= mod_add(num_q, A);
                        u_q   <= den_init;
                        v_q   <= P;
                        ix1_q <= F_ONE;
                        ix2_q <= '0;
                    end
                end
                S_INV: begin
                    if (inv_fin) begin
                        if (u_q == F_ONE)      den_q <= ix1_q;
                        else if (v_q == F_ONE) den_q <= ix2_q;
                        else                   den_q <= '0;
                    end else begin
                        u_q <= u_n; v_q <= v_n; ix1_q <= ix1_n; ix2_q <= ix2_n;
                    end
                end
                S_LAMBDA: begin
                    if (mul_run) acc_q <= mul_next;
                    else         lam_q <= acc_q;
                end
                S_SQ: begin
                    if (mul_run) acc_q <= mul_next;
                    else         t_q   <= acc_q;
                end
                S_X3: begin
                    if (cnt_q == '0) t_q   <= mod_sub(t_q, x1_q);
                    else             x3w_q <= mod_sub(t_q, x2_q);
                end
                S_DIFF: t_q <= mod_sub(x1_q, x3w_q);
                S_MULY: begin
                    if (mul_run) acc_q <= mul_next;
                    else         t_q   <= acc_q;
                end
                S_Y3: begin
                    x3_q   <= x3w_q;
                    y3_q   <= mod_sub(t_q, y1_q);
                    inf3_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
